edge_req_scheduler: RTL and testbench



---
 rtl/edge_sched_pkg.sv | 36 +++
 rtl/level_edge_detect.sv | 17 +
 rtl/edge_req_scheduler.sv | 105 ++++++++++
 tb/tb_edge_req_scheduler.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/edge_sched_pkg.sv
// Shared types and round-robin helper for the edge-triggered request scheduler.
package edge_sched_pkg;

    localparam int unsigned MAX_N   = 16;
    localparam int unsigned MAX_IDW = 4;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    // First set bit of pend at or after ptr, wrapping at n-1 -> 0; returns 0 when pend is empty.
    function automatic logic [MAX_IDW-1:0] rr_pick(
        input logic [MAX_N-1:0]   pend,
        input logic [MAX_IDW-1:0] ptr,
        input int unsigned        n
    );
        logic [MAX_IDW-1:0] win;
        logic               found;
        int unsigned        idx;
        win   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < MAX_N; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= n) begin
                idx = idx - n;
            end
            if (k < n && !found && pend[MAX_IDW'(idx)]) begin
                win   = MAX_IDW'(idx);
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/level_edge_detect.sv
// One-bit rising-edge detector; prev always tracks the level, including during reset,
// so a level already high when reset releases never produces an edge.
module level_edge_detect (
    input  logic clk,
    input  logic level_i,
    output logic rise_c_o
);

    logic prev_q;

    always_ff @(posedge clk) begin
        prev_q <= level_i;
    end

    assign rise_c_o = level_i & ~prev_q;

endmodule

// File: rtl/edge_req_scheduler.sv
// Turns N level inputs into one-shot pending requests and grants them round-robin
// over a single valid/ready channel, flagging edges that land on an already-pending channel.
module edge_req_scheduler
    import edge_sched_pkg::*;
#(
    parameter int unsigned N   = 4,
    localparam int unsigned IDW = $clog2(N)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   level_in,
    input  logic           grant_ready,
    input  logic           ovf_clear,
    output logic           grant_valid,
    output logic [IDW-1:0] grant_id,
    output logic [N-1:0]   pending,
    output logic [N-1:0]   overflow
);

    logic [N-1:0]   edge_c;
    logic [N-1:0]   clr_mask_c;
    logic [N-1:0]   cand_c;
    logic           hs_c;

    state_e         state_q,    state_d;
    logic           gvalid_q,   gvalid_d;
    logic [IDW-1:0] gid_q,      gid_d;
    logic [IDW-1:0] ptr_q,      ptr_d;
    logic [N-1:0]   pending_q,  pending_d;
    logic [N-1:0]   overflow_q, overflow_d;

    for (genvar i = 0; i < N; i++) begin : g_edge
        level_edge_detect u_edge (
            .clk      (clk),
            .level_i  (level_in[i]),
            .rise_c_o (edge_c[i])
        );
    end

    // Handshake clears the granted bit; a fresh edge on the same channel re-sets it.
    always_comb begin
        hs_c       = gvalid_q & grant_ready;
        clr_mask_c = hs_c ? (N'(1) << gid_q) : '0;
        pending_d  = (pending_q & ~clr_mask_c) | edge_c;
        overflow_d = (ovf_clear ? '0 : overflow_q) | (edge_c & pending_q & ~clr_mask_c);
        cand_c     = (pending_q | edge_c) & ~clr_mask_c;
    end

    always_comb begin
        state_d  = state_q;
        gvalid_d = gvalid_q;
        gid_d    = gid_q;
        ptr_d    = ptr_q;
        case (state_q)
            ST_IDLE: begin
                gvalid_d = 1'b0;
                if (|pending_q) begin
                    gid_d    = IDW'(rr_pick(MAX_N'(pending_q), MAX_IDW'(ptr_q), N));
                    gvalid_d = 1'b1;
                    state_d  = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // Winner is excluded from back-to-back reselection even if it re-edged this cycle.
                if (grant_ready) begin
                    ptr_d = (32'(gid_q) == N - 1) ? '0 : gid_q + IDW'(1);
                    if (|cand_c) begin
                        gid_d = IDW'(rr_pick(MAX_N'(cand_c), MAX_IDW'(ptr_d), N));
                    end else begin
                        gvalid_d = 1'b0;
                        state_d  = ST_IDLE;
                    end
                end
            end
            default: begin
                gvalid_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            gvalid_q   <= 1'b0;
            gid_q      <= '0;
            ptr_q      <= '0;
            pending_q  <= '0;
            overflow_q <= '0;
        end else begin
            state_q    <= state_d;
            gvalid_q   <= gvalid_d;
            gid_q      <= gid_d;
            ptr_q      <= ptr_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    assign grant_valid = gvalid_q;
    assign grant_id    = gid_q;
    assign pending     = pending_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_edge_req_scheduler.sv
// Directed bench for edge_req_scheduler with hand-computed expectations.
module tb_edge_req_scheduler;

    localparam int unsigned N   = 4;
    localparam int unsigned IDW = $clog2(N);

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   level_in;
    logic           grant_ready;
    logic           ovf_clear;
    logic           grant_valid;
    logic [IDW-1:0] grant_id;
    logic [N-1:0]   pending;
    logic [N-1:0]   overflow;

    int n_checks = 0;
    int n_pass   = 0;

    edge_req_scheduler #(.N(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .level_in    (level_in),
        .grant_ready (grant_ready),
        .ovf_clear   (ovf_clear),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .pending     (pending),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic gv, input logic [IDW-1:0] gid,
                           input logic [N-1:0] pend, input logic [N-1:0] ovf);
        check({tag, ".gv"}, 32'(grant_valid), 32'(gv));
        if (gv) check({tag, ".id"}, 32'(grant_id), 32'(gid));
        check({tag, ".pend"}, 32'(pending), 32'(pend));
        check({tag, ".ovf"}, 32'(overflow), 32'(ovf));
    endtask

    initial begin
        reset       = 1'b1;
        level_in    = 4'b0010;
        grant_ready = 1'b0;
        ovf_clear   = 1'b0;
        step();
        step();
        chk_all("rst", 1'b0, '0, 4'b0000, 4'b0000);
        check("rst.id", 32'(grant_id), 32'd0);

        // Level already high at release: no edge, no grant.
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            check("held.gv", 32'(grant_valid), 32'd0);
            check("held.pend", 32'(pending), 32'd0);
        end

        // Single edge on ch2: pending then grant then cleared.
        grant_ready = 1'b1;
        level_in    = 4'b0110;
        step(); chk_all("ch2.t",  1'b0, 2'd0, 4'b0100, 4'b0000);
        step(); chk_all("ch2.t1", 1'b1, 2'd2, 4'b0100, 4'b0000);
        step(); chk_all("ch2.t2", 1'b0, 2'd0, 4'b0000, 4'b0000);
        level_in = 4'b0000;
        step();

        // Reset to bring pointer back to 0, then three simultaneous edges.
        reset = 1'b1; step(); reset = 1'b0; step();
        level_in = 4'b1011;
        step(); chk_all("b2b.p",  1'b0, 2'd0, 4'b1011, 4'b0000);
        step(); chk_all("b2b.g0", 1'b1, 2'd0, 4'b1011, 4'b0000);
        step(); chk_all("b2b.g1", 1'b1, 2'd1, 4'b1010, 4'b0000);
        step(); chk_all("b2b.g3", 1'b1, 2'd3, 4'b1000, 4'b0000);
        step(); chk_all("b2b.end", 1'b0, 2'd0, 4'b0000, 4'b0000);
        // Pointer at 0: ch0 wins over ch2.
        level_in = 4'b0000; step();
        level_in = 4'b0101;
        step(); chk_all("ptr.p",  1'b0, 2'd0, 4'b0101, 4'b0000);
        step(); chk_all("ptr.g0", 1'b1, 2'd0, 4'b0101, 4'b0000);
        step(); chk_all("ptr.g2", 1'b1, 2'd2, 4'b0100, 4'b0000);
        step(); chk_all("ptr.end", 1'b0, 2'd0, 4'b0000, 4'b0000);

        // Overflow on ch1 while its grant is stalled.
        level_in = 4'b0000; grant_ready = 1'b0; step();
        level_in = 4'b0010;
        step(); chk_all("ovf.p", 1'b0, 2'd0, 4'b0010, 4'b0000);
        step(); chk_all("ovf.g", 1'b1, 2'd1, 4'b0010, 4'b0000);
        level_in = 4'b0000;
        step(); chk_all("ovf.lo", 1'b1, 2'd1, 4'b0010, 4'b0000);
        level_in = 4'b0010;
        step(); chk_all("ovf.hi", 1'b1, 2'd1, 4'b0010, 4'b0010);
        ovf_clear = 1'b1;
        step(); chk_all("ovf.clr", 1'b1, 2'd1, 4'b0010, 4'b0000);
        ovf_clear = 1'b0;
        // Clear and new overflow in the same cycle: new overflow wins.
        level_in = 4'b0000; step();
        level_in = 4'b0010; ovf_clear = 1'b1;
        step(); chk_all("ovf.win", 1'b1, 2'd1, 4'b0010, 4'b0010);
        ovf_clear = 1'b0;
        grant_ready = 1'b1;
        step(); chk_all("ovf.hs", 1'b0, 2'd0, 4'b0000, 4'b0010);
        ovf_clear = 1'b1; level_in = 4'b0000;
        step(); check("ovf.clr2", 32'(overflow), 32'd0);
        ovf_clear = 1'b0;

        // ch3 handshake coinciding with a fresh ch3 edge.
        grant_ready = 1'b0;
        level_in = 4'b1000;
        step(); chk_all("hs3.p", 1'b0, 2'd0, 4'b1000, 4'b0000);
        step(); chk_all("hs3.g", 1'b1, 2'd3, 4'b1000, 4'b0000);
        level_in = 4'b0000;
        step(); chk_all("hs3.hold", 1'b1, 2'd3, 4'b1000, 4'b0000);
        level_in = 4'b1000; grant_ready = 1'b1;
        step(); chk_all("hs3.hs", 1'b0, 2'd0, 4'b1000, 4'b0000);
        step(); chk_all("hs3.re", 1'b1, 2'd3, 4'b1000, 4'b0000);
        step(); chk_all("hs3.end", 1'b0, 2'd0, 4'b0000, 4'b0000);

        // Reset while a grant is offered.
        grant_ready = 1'b0; level_in = 4'b0000; step();
        level_in = 4'b1011;
        step(); chk_all("mr.p", 1'b0, 2'd0, 4'b1011, 4'b0000);
        step(); chk_all("mr.g", 1'b1, 2'd0, 4'b1011, 4'b0000);
        reset = 1'b1; grant_ready = 1'b1;
        step(); chk_all("mr.rst", 1'b0, 2'd0, 4'b0000, 4'b0000);
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step(); chk_all("mr.idle", 1'b0, 2'd0, 4'b0000, 4'b0000);
        end
        level_in = 4'b1111;
        step(); chk_all("mr.new", 1'b0, 2'd0, 4'b0100, 4'b0000);
        step(); chk_all("mr.g2",  1'b1, 2'd2, 4'b0100, 4'b0000);
        step(); chk_all("mr.end", 1'b0, 2'd0, 4'b0000, 4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
